// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency sweep controller.
package sweep_pkg;

  localparam int unsigned ACC_W_DEF = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL,
    S_EMIT,
    S_NEXT
  } state_e;

  // A dwell of zero still takes one sample per point.
  function automatic logic [15:0] dwell_eff(input logic [15:0] d);
    return (d == '0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sample_counter.sv
// Down-counter of accepted sample strobes; flags the last one of a run.
module sample_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        cnt_i,
  output logic        term_o
);

  logic [15:0] cnt_q, cnt_d;

  // Load takes priority over counting; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == 16'd1);

endmodule

// File: rtl/sweep_ctrl.sv
// Stepped-frequency sweep controller: steps the DDS increment, discards
// settling samples, accumulates dwell samples and hands each point out.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter logic [31:0] RESET_INC = 32'd500000,
  parameter int          ACC_W     = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             start_inc,
  input  logic [31:0]             stop_inc,
  input  logic [31:0]             step_inc,
  input  logic [15:0]             dwell,
  input  logic [7:0]              settle,
  input  logic                    sample_stb,
  input  logic [23:0]             adc_data,
  output logic [31:0]             phase_inc,
  output logic                    busy,
  output logic                    pt_valid,
  input  logic                    pt_ready,
  output logic [31:0]             pt_inc,
  output logic signed [ACC_W-1:0] pt_acc,
  output logic                    done
);

  state_e                  state_q, state_d;
  logic [31:0]             phase_q, phase_d;
  logic [31:0]             stop_q, stop_d;
  logic [31:0]             step_q, step_d;
  logic [15:0]             dwell_q, dwell_d;
  logic [7:0]              settle_q, settle_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [31:0]             pinc_q, pinc_d;
  logic signed [ACC_W-1:0] pacc_q, pacc_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext, acc_sum;
  logic [32:0]             nxt;
  logic                    sweep_end;
  logic                    strobe_ok, cnt_term, cnt_last, cnt_load;
  logic [15:0]             cnt_val;

  // Strobes only count while the state register already holds SETTLE or
  // DWELL, so a strobe on an entry edge is never credited to the new state.
  assign strobe_ok  = sample_stb && ((state_q == S_SETTLE) || (state_q == S_DWELL));
  assign cnt_last   = strobe_ok && cnt_term;
  assign sample_ext = {{(ACC_W-24){adc_data[23]}}, adc_data};
  assign acc_sum    = acc_q + sample_ext;
  assign nxt        = {1'b0, phase_q} + {1'b0, step_q};
  assign sweep_end  = (step_q == '0) || nxt[32] || (nxt[31:0] > stop_q);

  sample_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .cnt_i      (strobe_ok),
    .term_o     (cnt_term)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= RESET_INC;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      pinc_q   <= '0;
      pacc_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      pinc_q   <= pinc_d;
      pacc_q   <= pacc_d;
      acc_q    <= acc_d;
    end
  end

  // Next-state selection; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start && !abort) state_d = S_SETTLE;
        S_SETTLE: if ((settle_q == '0) || cnt_last) state_d = S_DWELL;
        S_DWELL:  if (cnt_last) state_d = S_EMIT;
        S_EMIT:   if (pt_ready) state_d = S_NEXT;
        S_NEXT:   state_d = sweep_end ? S_IDLE : S_SETTLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Registered-output and datapath next values.
  always_comb begin
    phase_d  = phase_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    pinc_d   = pinc_q;
    pacc_d   = pacc_q;
    acc_d    = acc_q;
    cnt_load = 1'b0;
    cnt_val  = {8'd0, settle_q};
    if (abort && (state_q != S_IDLE)) begin
      busy_d  = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            phase_d  = start_inc;
            stop_d   = stop_inc;
            step_d   = step_inc;
            dwell_d  = dwell;
            settle_d = settle;
            acc_d    = '0;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = {8'd0, settle};
          end
        end
        S_SETTLE: begin
          if ((settle_q == '0) || cnt_last) begin
            cnt_load = 1'b1;
            cnt_val  = dwell_eff(dwell_q);
          end
        end
        S_DWELL: begin
          if (strobe_ok) acc_d = acc_sum;
          if (cnt_last) begin
            valid_d = 1'b1;
            pinc_d  = phase_q;
            pacc_d  = acc_sum;
          end
        end
        S_EMIT: begin
          if (pt_ready) valid_d = 1'b0;
        end
        S_NEXT: begin
          if (sweep_end) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            phase_d  = nxt[31:0];
            acc_d    = '0;
            cnt_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase_inc = phase_q;
  assign busy      = busy_q;
  assign pt_valid  = valid_q;
  assign pt_inc    = pinc_q;
  assign pt_acc    = pacc_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl.
module tb_sweep_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, abort = 1'b0;
  logic [31:0]        start_inc = '0, stop_inc = '0, step_inc = '0;
  logic [15:0]        dwell = '0;
  logic [7:0]         settle = '0;
  logic               sample_stb = 1'b0;
  logic [23:0]        adc_data = '0;
  logic [31:0]        phase_inc;
  logic               busy, pt_valid;
  logic               pt_ready = 1'b0;
  logic [31:0]        pt_inc;
  logic signed [39:0] pt_acc;
  logic               done;

  int total = 0;
  int bad   = 0;

  sweep_ctrl #(.RESET_INC(32'd500000), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_inc(start_inc), .stop_inc(stop_inc), .step_inc(step_inc),
    .dwell(dwell), .settle(settle), .sample_stb(sample_stb), .adc_data(adc_data),
    .phase_inc(phase_inc), .busy(busy), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_inc(pt_inc), .pt_acc(pt_acc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic clk_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) clk_cycle();
    rst_n = 1'b1;
    clk_cycle();
    total++; if (phase_inc !== 32'd500000) begin bad++; $display("FAIL reset_phase got=%0d exp=500000", phase_inc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pt_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (pt_inc !== 32'd0) begin bad++; $display("FAIL reset_pt_inc got=%0d exp=0", pt_inc); end
    total++; if (pt_acc !== 40'sd0) begin bad++; $display("FAIL reset_pt_acc got=%0d exp=0", pt_acc); end
  endtask

  task automatic test_sweep;
    logic [31:0]        pinc[3];
    logic signed [39:0] pacc[3];
    int npts = 0;
    bit got_done = 0;
    start_inc = 32'd1000; stop_inc = 32'd3000; step_inc = 32'd1000;
    settle = 8'd2; dwell = 16'd4; adc_data = 24'd5; pt_ready = 1'b1;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sweep_busy_rise got=%b exp=1", busy); end
    total++; if (phase_inc !== 32'd1000) begin bad++; $display("FAIL sweep_phase_load got=%0d exp=1000", phase_inc); end
    for (int n = 0; n < 400; n++) begin
      sample_stb = (n % 3 == 0);
      clk_cycle();
      if (pt_valid) begin
        if (npts < 3) begin pinc[npts] = pt_inc; pacc[npts] = pt_acc; end
        npts++;
      end
      if (done) begin got_done = 1; break; end
    end
    sample_stb = 1'b0;
    total++; if (!got_done) begin bad++; $display("FAIL sweep_done got=timeout exp=pulse"); end
    total++; if (npts != 3) begin bad++; $display("FAIL sweep_npts got=%0d exp=3", npts); end
    for (int i = 0; i < 3 && i < npts; i++) begin
      total++; if (pinc[i] !== 32'(1000 * (i + 1))) begin bad++; $display("FAIL sweep_pt_inc[%0d] got=%0d exp=%0d", i, pinc[i], 1000 * (i + 1)); end
      total++; if (pacc[i] !== 40'sd20) begin bad++; $display("FAIL sweep_pt_acc[%0d] got=%0d exp=20", i, pacc[i]); end
    end
    total++; if (phase_inc !== 32'd3000) begin bad++; $display("FAIL sweep_phase_end got=%0d exp=3000", phase_inc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sweep_busy_end got=%b exp=0", busy); end
    clk_cycle();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL sweep_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_one_point;
    int npts = 0;
    bit got_done = 0;
    logic [31:0]        inc0 = '0;
    logic signed [39:0] acc0 = '0;
    start_inc = 32'd100; stop_inc = 32'd50; step_inc = 32'd10;
    settle = 8'd0; dwell = 16'd0; adc_data = 24'hFFFFFD; pt_ready = 1'b1;
    pulse_start();
    sample_stb = 1'b1;
    for (int n = 0; n < 50; n++) begin
      clk_cycle();
      if (pt_valid) begin if (npts == 0) begin inc0 = pt_inc; acc0 = pt_acc; end npts++; end
      if (done) begin got_done = 1; break; end
    end
    sample_stb = 1'b0;
    total++; if (!got_done) begin bad++; $display("FAIL one_done got=timeout exp=pulse"); end
    total++; if (npts != 1) begin bad++; $display("FAIL one_npts got=%0d exp=1", npts); end
    total++; if (inc0 !== 32'd100) begin bad++; $display("FAIL one_pt_inc got=%0d exp=100", inc0); end
    total++; if (acc0 !== -40'sd3) begin bad++; $display("FAIL one_pt_acc got=%0d exp=-3", acc0); end
  endtask

  task automatic test_backpressure;
    bit seen = 0, held_ok = 1, got_done = 0;
    int npts = 0;
    logic [31:0]        inc1 = '0;
    logic signed [39:0] acc1 = '0;
    start_inc = 32'd10; stop_inc = 32'd11; step_inc = 32'd1;
    settle = 8'd1; dwell = 16'd2; adc_data = 24'd7; pt_ready = 1'b0;
    pulse_start();
    sample_stb = 1'b1;
    for (int n = 0; n < 50; n++) begin
      clk_cycle();
      if (pt_valid) begin seen = 1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_valid got=timeout exp=1"); end
    total++; if (pt_acc !== 40'sd14) begin bad++; $display("FAIL bp_first_acc got=%0d exp=14", pt_acc); end
    adc_data = 24'd100;
    for (int n = 0; n < 50; n++) begin
      clk_cycle();
      if (pt_valid !== 1'b1 || pt_acc !== 40'sd14 || pt_inc !== 32'd10) held_ok = 0;
    end
    total++; if (!held_ok) begin bad++; $display("FAIL bp_hold got=changed exp=valid,acc14,inc10 (now v=%b acc=%0d)", pt_valid, pt_acc); end
    pt_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      clk_cycle();
      if (pt_valid) begin if (npts == 0) begin inc1 = pt_inc; acc1 = pt_acc; end npts++; end
      if (done) begin got_done = 1; break; end
    end
    sample_stb = 1'b0;
    total++; if (!got_done) begin bad++; $display("FAIL bp_done got=timeout exp=pulse"); end
    total++; if (npts != 1) begin bad++; $display("FAIL bp_npts got=%0d exp=1", npts); end
    total++; if (inc1 !== 32'd11) begin bad++; $display("FAIL bp_second_inc got=%0d exp=11", inc1); end
    total++; if (acc1 !== 40'sd200) begin bad++; $display("FAIL bp_second_acc got=%0d exp=200", acc1); end
  endtask

  task automatic test_abort;
    bit seen = 0, moved = 0;
    start_inc = 32'd1000; stop_inc = 32'd3000; step_inc = 32'd1000;
    settle = 8'd2; dwell = 16'd4; adc_data = 24'd5; pt_ready = 1'b1;
    pulse_start();
    for (int n = 0; n < 100; n++) begin
      sample_stb = (n % 3 == 0);
      clk_cycle();
      if (pt_valid) begin seen = 1; break; end
    end
    sample_stb = 1'b0;
    total++; if (!seen || pt_inc !== 32'd1000) begin bad++; $display("FAIL abort_pt1 got=%0d exp=1000", pt_inc); end
    for (int n = 0; n < 20; n++) begin
      clk_cycle();
      if (phase_inc == 32'd2000) begin moved = 1; break; end
    end
    total++; if (!moved) begin bad++; $display("FAIL abort_step got=%0d exp=2000", phase_inc); end
    start_inc = 32'd7777;
    pulse_start();
    total++; if (phase_inc !== 32'd2000 || busy !== 1'b1) begin bad++; $display("FAIL start_while_busy got=%0d/%b exp=2000/1", phase_inc, busy); end
    repeat (3) begin
      sample_stb = 1'b1; clk_cycle();
      sample_stb = 1'b0; clk_cycle();
    end
    abort = 1'b1;
    clk_cycle();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b exp=1", done); end
    total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", pt_valid); end
    total++; if (phase_inc !== 32'd2000) begin bad++; $display("FAIL abort_phase got=%0d exp=2000", phase_inc); end
    clk_cycle();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_pulse got=%b exp=0", done); end
    start_inc = 32'd9999;
    start = 1'b1; abort = 1'b1;
    clk_cycle();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || phase_inc !== 32'd2000 || done !== 1'b0) begin bad++; $display("FAIL abort_with_start got=busy%b/%0d/done%b exp=busy0/2000/done0", busy, phase_inc, done); end
  endtask

  task automatic test_carry;
    int npts = 0;
    bit got_done = 0;
    logic [31:0]        inc0 = '0;
    logic signed [39:0] acc0 = '0;
    start_inc = 32'hFFFFF000; stop_inc = 32'hFFFFFFFF; step_inc = 32'h2000;
    settle = 8'd0; dwell = 16'd1; adc_data = 24'd1; pt_ready = 1'b1;
    pulse_start();
    sample_stb = 1'b1;
    for (int n = 0; n < 50; n++) begin
      clk_cycle();
      if (pt_valid) begin if (npts == 0) begin inc0 = pt_inc; acc0 = pt_acc; end npts++; end
      if (done) begin got_done = 1; break; end
    end
    sample_stb = 1'b0;
    total++; if (!got_done) begin bad++; $display("FAIL carry_done got=timeout exp=pulse"); end
    total++; if (npts != 1) begin bad++; $display("FAIL carry_npts got=%0d exp=1", npts); end
    total++; if (inc0 !== 32'hFFFFF000 || acc0 !== 40'sd1) begin bad++; $display("FAIL carry_point got=%h/%0d exp=fffff000/1", inc0, acc0); end
    total++; if (phase_inc !== 32'hFFFFF000) begin bad++; $display("FAIL carry_phase got=%h exp=fffff000", phase_inc); end
  endtask

  task automatic test_reset_mid;
    start_inc = 32'd4000; stop_inc = 32'd8000; step_inc = 32'd1000;
    settle = 8'd3; dwell = 16'd2; pt_ready = 1'b1;
    pulse_start();
    sample_stb = 1'b1; clk_cycle(); sample_stb = 1'b0;
    total++; if (busy !== 1'b1 || phase_inc !== 32'd4000) begin bad++; $display("FAIL rmid_pre got=%b/%0d exp=1/4000", busy, phase_inc); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (phase_inc !== 32'd500000) begin bad++; $display("FAIL rmid_phase got=%0d exp=500000", phase_inc); end
    total++; if (busy !== 1'b0 || pt_valid !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b/%b exp=0/0", busy, pt_valid); end
    clk_cycle();
    rst_n = 1'b1;
    repeat (5) clk_cycle();
    total++; if (busy !== 1'b0 || done !== 1'b0 || pt_valid !== 1'b0 || phase_inc !== 32'd500000) begin bad++; $display("FAIL rmid_after got=%b/%b/%b/%0d exp=0/0/0/500000", busy, done, pt_valid, phase_inc); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_one_point();
    test_backpressure();
    test_abort();
    test_carry();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
